// File: rtl/film_advance_seq.sv
// film_advance_seq
// Motion sequencer that drives the stepper motor_control stage. Accepts a
// counted move or a home seek, shapes a trapezoidal (or triangular) speed
// profile through the motor_control divisor, counts the step edges that
// motor_control actually issues, and ends the motion on step count, home
// sensor, driver fault or home-seek timeout.
//
// Ports
//   clk_100MHz   in   system clock
//   rst          in   synchronous active-high reset
//   cmd_valid    in   command offered
//   cmd_ready    out  high only while idle; accept = cmd_valid && cmd_ready
//   cmd_home     in   1 = home seek, 0 = counted move
//   cmd_steps    in   [23:0] step count for a counted move
//   mtr_en       out  motor_control enable
//   mtr_div      out  [7:0] motor_control speed divisor (larger = slower)
//   mtr_step_fb  in   motor_control step output (synchronous)
//   mtr_nhome    in   home sensor, active low, asynchronous
//   mtr_nflt     in   driver fault, active low, asynchronous
//   busy         out  high whenever not idle
//   done         out  one-cycle completion pulse (success or error)
//   err          out  high while err_code != 0
//   err_code     out  [1:0] 0 none, 1 driver fault, 2 home timeout
//   steps_done   out  [23:0] step edges counted for the current/last command
module film_advance_seq #(
  parameter logic [7:0]  DIV_START   = 8'd40,
  parameter logic [7:0]  DIV_RUN     = 8'd4,
  parameter int          RAMP_STEPS  = 16,
  parameter logic [23:0] HOME_MAX    = 24'd200000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_home,
  input  logic [23:0] cmd_steps,
  output logic        mtr_en,
  output logic [7:0]  mtr_div,
  input  logic        mtr_step_fb,
  input  logic        mtr_nhome,
  input  logic        mtr_nflt,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [23:0] steps_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEL, S_CRUISE, S_DECEL, S_HOME, S_FINISH
  } state_t;

  localparam logic [15:0] RAMP_LAST = 16'(RAMP_STEPS - 1);

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] nhome_sync_q, nflt_sync_q;
  logic        step_prev_q;
  logic [23:0] target_q, target_d;
  logic [23:0] accel_steps_q, accel_steps_d;
  logic [23:0] steps_done_q, steps_done_d;
  logic [15:0] ramp_cnt_q, ramp_cnt_d;
  logic        mtr_en_q, mtr_en_d;
  logic [7:0]  mtr_div_q, mtr_div_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  // Derived per-cycle conditions shared by the next-state and output logic
  logic        home_n, flt_n, accept, step_evt, ramp_wrap, moving, fault_stop;
  logic        target_hit, home_limit, run_reached;
  logic        decel_from_accel, decel_from_cruise;
  logic [23:0] steps_inc, remain_after;
  logic [7:0]  div_dec;

  assign home_n   = nhome_sync_q[SYNC_STAGES-1];
  assign flt_n    = nflt_sync_q[SYNC_STAGES-1];
  assign accept   = cmd_valid && cmd_ready_q;
  // Only edges issued while we are enabling the motor belong to this command
  assign step_evt = mtr_en_q && mtr_step_fb && !step_prev_q;
  assign steps_inc = (steps_done_q == 24'hFFFFFF) ? steps_done_q : steps_done_q + 24'd1;
  // Steps still to go once the edge arriving this cycle is counted
  assign remain_after = (steps_inc >= target_q) ? 24'd0 : target_q - steps_inc;
  assign ramp_wrap  = (ramp_cnt_q >= RAMP_LAST);
  assign div_dec    = mtr_div_q - 8'd1;
  assign target_hit = (steps_done_q >= target_q);
  assign home_limit = (steps_done_q >= HOME_MAX);
  assign moving     = (state_q == S_ACCEL) || (state_q == S_CRUISE) ||
                      (state_q == S_DECEL) || (state_q == S_HOME);
  assign fault_stop = moving && !flt_n;
  // The accel step itself counts toward the decel distance, hence +1
  assign decel_from_accel  = step_evt && (remain_after <= accel_steps_q + 24'd1);
  assign decel_from_cruise = step_evt && (remain_after <= accel_steps_q);
  assign run_reached = (mtr_div_q <= DIV_RUN) ||
                       (step_evt && ramp_wrap && (div_dec <= DIV_RUN));

  // Sensor synchronisers, idle high (inactive)
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      nhome_sync_q <= '1;
      nflt_sync_q  <= '1;
    end else begin
      nhome_sync_q[0] <= mtr_nhome;
      nflt_sync_q[0]  <= mtr_nflt;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        nhome_sync_q[i] <= nhome_sync_q[i-1];
        nflt_sync_q[i]  <= nflt_sync_q[i-1];
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q       <= S_IDLE;
      step_prev_q   <= 1'b0;
      target_q      <= '0;
      accel_steps_q <= '0;
      steps_done_q  <= '0;
      ramp_cnt_q    <= '0;
      mtr_en_q      <= 1'b0;
      mtr_div_q     <= DIV_START;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      step_prev_q   <= mtr_step_fb;
      target_q      <= target_d;
      accel_steps_q <= accel_steps_d;
      steps_done_q  <= steps_done_d;
      ramp_cnt_q    <= ramp_cnt_d;
      mtr_en_q      <= mtr_en_d;
      mtr_div_q     <= mtr_div_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  // Next-state logic; a fault outranks every other exit
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_home)               state_d = S_HOME;
          else if (cmd_steps == 24'd0) state_d = S_FINISH;
          else                        state_d = S_ACCEL;
        end
      end
      S_ACCEL: begin
        if (fault_stop || target_hit) state_d = S_FINISH;
        else if (decel_from_accel)    state_d = S_DECEL;
        else if (run_reached)         state_d = S_CRUISE;
      end
      S_CRUISE: begin
        if (fault_stop || target_hit) state_d = S_FINISH;
        else if (decel_from_cruise)   state_d = S_DECEL;
      end
      S_DECEL: begin
        if (fault_stop || target_hit) state_d = S_FINISH;
      end
      S_HOME: begin
        if (fault_stop || !home_n || home_limit) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    target_d      = target_q;
    accel_steps_d = accel_steps_q;
    steps_done_d  = steps_done_q;
    ramp_cnt_d    = ramp_cnt_q;
    mtr_div_d     = mtr_div_q;
    err_code_d    = err_code_q;

    if (state_q == S_IDLE && accept) begin
      target_d      = cmd_steps;
      accel_steps_d = '0;
      steps_done_d  = '0;
      ramp_cnt_d    = '0;
      err_code_d    = 2'd0;
    end else if (step_evt) begin
      steps_done_d = steps_inc;
    end

    case (state_q)
      S_ACCEL: begin
        if (step_evt) begin
          accel_steps_d = accel_steps_q + 24'd1;
          if (ramp_wrap) begin
            ramp_cnt_d = '0;
            if (mtr_div_q > DIV_RUN) mtr_div_d = div_dec;
          end else begin
            ramp_cnt_d = ramp_cnt_q + 16'd1;
          end
        end
      end
      S_DECEL: begin
        if (step_evt) begin
          if (ramp_wrap) begin
            ramp_cnt_d = '0;
            if (mtr_div_q < DIV_START) mtr_div_d = mtr_div_q + 8'd1;
          end else begin
            ramp_cnt_d = ramp_cnt_q + 16'd1;
          end
        end
      end
      default: ;
    endcase

    // The deceleration ramp measures its own RAMP_STEPS groups from entry
    if (state_d == S_DECEL && state_q != S_DECEL) ramp_cnt_d = '0;

    if (state_q == S_IDLE || state_d == S_IDLE || state_d == S_FINISH ||
        state_d == S_HOME)
      mtr_div_d = DIV_START;

    if (fault_stop)
      err_code_d = 2'd1;
    else if (state_q == S_HOME && home_n && home_limit)
      err_code_d = 2'd2;

    case (state_d)
      S_ACCEL, S_CRUISE, S_DECEL: mtr_en_d = 1'b1;
      // Starting a seek already at home must not issue any step
      S_HOME:  mtr_en_d = (state_q == S_IDLE) ? home_n : 1'b1;
      default: mtr_en_d = 1'b0;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
    err_d       = (err_code_d != 2'd0);
  end

  assign cmd_ready  = cmd_ready_q;
  assign mtr_en     = mtr_en_q;
  assign mtr_div    = mtr_div_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign steps_done = steps_done_q;

endmodule

// File: tb/tb_film_advance_seq.sv
// Bench for film_advance_seq with a small motor_control model; all checks
// and stimulus run in one process driven cycle by cycle through tick().
module tb_film_advance_seq;

  localparam logic [7:0]  DS = 8'd8;
  localparam logic [7:0]  DR = 8'd4;
  localparam int          RS = 2;
  localparam logic [23:0] HM = 24'd100;

  logic        clk_100MHz = 1'b0;
  logic        rst, cmd_valid, cmd_home, mtr_step_fb, mtr_nhome, mtr_nflt;
  logic [23:0] cmd_steps;
  logic        cmd_ready, mtr_en, busy, done, err;
  logic [7:0]  mtr_div;
  logic [1:0]  err_code;
  logic [23:0] steps_done;

  int checks = 0;
  int failures = 0;

  // Model state
  int model_edges = 0, done_cnt = 0, min_div = 255, mode = 0, tgt = 0;
  int pend = 0, pend_tgt = 0, pend_mode = 0, mcnt = 0;
  int en_seen = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  film_advance_seq #(
    .DIV_START(DS), .DIV_RUN(DR), .RAMP_STEPS(RS), .HOME_MAX(HM), .SYNC_STAGES(2)
  ) dut (
    .clk_100MHz(clk_100MHz), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_home(cmd_home), .cmd_steps(cmd_steps), .mtr_en(mtr_en), .mtr_div(mtr_div),
    .mtr_step_fb(mtr_step_fb), .mtr_nhome(mtr_nhome), .mtr_nflt(mtr_nflt),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .steps_done(steps_done)
  );

  // Required divisor after n counted steps of a move of t steps:
  // accelerate one unit per RS steps until DR, decelerate once the remaining
  // distance is no larger than the distance spent accelerating.
  function automatic int prof(input int t, input int n);
    int dv, acc, cnt, ph;
    dv = int'(DS); acc = 0; cnt = 0; ph = 0;
    for (int k = 1; k <= n; k++) begin
      if (ph == 0) begin
        acc++; cnt++;
        if (cnt == RS) begin cnt = 0; dv--; end
        if (t - k <= acc) begin ph = 2; cnt = 0; end
        else if (dv == int'(DR)) ph = 1;
      end else if (ph == 1) begin
        if (t - k <= acc) begin ph = 2; cnt = 0; end
      end else begin
        cnt++;
        if (cnt == RS) begin cnt = 0; if (dv < int'(DS)) dv++; end
      end
    end
    return dv;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // One clock cycle: per-cycle compare and motor model on the falling edge,
  // then return 1 time unit after the rising edge for stimulus.
  task automatic tick();
    @(negedge clk_100MHz);
    if (rst) begin
      mode = 0; pend = 0;
    end else begin
      if (pend != 0) begin
        model_edges = 0; done_cnt = 0; en_seen = 0; min_div = 255;
        tgt = pend_tgt; mode = pend_mode;
      end
      if (mode != 0) begin
        chk("steps_done_track", int'(steps_done), model_edges);
        if (busy && !done) begin
          chk("mtr_div_profile", int'(mtr_div), (mode == 1) ? prof(tgt, model_edges) : int'(DS));
          if (int'(mtr_div) < min_div) min_div = int'(mtr_div);
        end
        if (done) done_cnt++;
        if (mtr_en) en_seen = 1;
      end
      pend = (cmd_valid && cmd_ready) ? 1 : 0;
      pend_tgt = int'(cmd_steps);
      pend_mode = cmd_home ? 2 : 1;
    end
    // motor_control: one-cycle step pulse every mtr_div cycles while enabled
    if (mtr_en) begin
      if (mcnt >= int'(mtr_div) - 1) begin
        mcnt = 0; mtr_step_fb = 1'b1; model_edges++;
      end else begin
        mcnt++; mtr_step_fb = 1'b0;
      end
    end else begin
      mcnt = 0; mtr_step_fb = 1'b0;
    end
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic issue(input logic home, input int steps);
    chk("ready_before_cmd", int'(cmd_ready), 1);
    cmd_home = home; cmd_steps = 24'(steps); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (!done && cyc < maxc) begin tick(); cyc++; end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=no_done_after_%0d_cycles required=done", maxc);
    end
  endtask

  task automatic wait_edges(input int n, input int maxc);
    int c;
    c = 0;
    while (model_edges < n && c < maxc) begin tick(); c++; end
    if (model_edges < n) begin
      checks++; failures++;
      $display("FAIL edge_timeout actual=%0d required=%0d", model_edges, n);
    end
  endtask

  task automatic en_drop(output int lat);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      tick(); lat++;
      if (!mtr_en) break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, lat;
    rst = 1'b1; cmd_valid = 1'b0; cmd_home = 1'b0; cmd_steps = '0;
    mtr_step_fb = 1'b0; mtr_nhome = 1'b1; mtr_nflt = 1'b1;

    // Hand-derived points of the 8->4 profile with RS=2
    chk("prof40_7", prof(40, 7), 5);
    chk("prof40_8", prof(40, 8), 4);
    chk("prof40_33", prof(40, 33), 4);
    chk("prof40_34", prof(40, 34), 5);
    chk("prof40_40", prof(40, 40), 8);
    chk("prof6_3", prof(6, 3), 7);
    chk("prof6_5", prof(6, 5), 8);

    repeat (3) tick();
    chk("rst_en", int'(mtr_en), 0);
    chk("rst_div", int'(mtr_div), 8);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_steps", int'(steps_done), 0);
    rst = 1'b0;
    tick();

    // Trapezoidal 40-step move
    issue(1'b0, 40);
    wait_done(3000, c);
    repeat (3) tick();
    chk("mv40_edges", model_edges, 40);
    chk("mv40_steps", int'(steps_done), 40);
    chk("mv40_done_pulses", done_cnt, 1);
    chk("mv40_err", int'(err), 0);
    chk("mv40_min_div", min_div, 4);
    chk("mv40_idle_en", int'(mtr_en), 0);
    $display("mv40: edges=%0d steps_done=%0d min_div=%0d", model_edges, steps_done, min_div);

    // Triangular 6-step move
    issue(1'b0, 6);
    wait_done(1000, c);
    repeat (3) tick();
    chk("mv6_edges", model_edges, 6);
    chk("mv6_steps", int'(steps_done), 6);
    chk("mv6_done_pulses", done_cnt, 1);
    chk("mv6_min_div", min_div, 7);
    $display("mv6: edges=%0d min_div=%0d", model_edges, min_div);

    // Zero-step move
    issue(1'b0, 0);
    wait_done(5, c);
    chk("zero_done_in_2", (c <= 2) ? 1 : 0, 1);
    repeat (3) tick();
    chk("zero_en_seen", en_seen, 0);
    chk("zero_steps", int'(steps_done), 0);
    chk("zero_done_pulses", done_cnt, 1);
    $display("zero: done_after=%0d en_seen=%0d", c, en_seen);

    // Home seek found after 50 edges
    issue(1'b1, 0);
    wait_edges(50, 2000);
    mtr_nhome = 1'b0;
    en_drop(lat);
    chk("home_en_latency", lat, 3);
    wait_done(10, c);
    repeat (3) tick();
    chk("home_err_code", int'(err_code), 0);
    chk("home_done_pulses", done_cnt, 1);
    chk("home_edges_50_51", (model_edges >= 50 && model_edges <= 51) ? 1 : 0, 1);
    $display("home: latency=%0d edges=%0d", lat, model_edges);

    // Seek starting at home issues nothing
    issue(1'b1, 0);
    wait_done(10, c);
    repeat (3) tick();
    chk("home_at_start_edges", model_edges, 0);
    chk("home_at_start_en", en_seen, 0);
    mtr_nhome = 1'b1;
    repeat (4) tick();

    // Home timeout at HOME_MAX
    issue(1'b1, 0);
    wait_done(3000, c);
    repeat (3) tick();
    chk("hto_steps", int'(steps_done), 100);
    chk("hto_edges", model_edges, 100);
    chk("hto_err_code", int'(err_code), 2);
    chk("hto_err", int'(err), 1);
    $display("home_timeout: steps_done=%0d err_code=%0d", steps_done, err_code);

    // Fault while idle is ignored
    mtr_nflt = 1'b0;
    repeat (5) tick();
    chk("idle_flt_busy", int'(busy), 0);
    chk("idle_flt_err_code", int'(err_code), 2);
    mtr_nflt = 1'b1;
    repeat (4) tick();

    // Fault at step 20 of a 200-step move
    issue(1'b0, 200);
    wait_edges(20, 2000);
    mtr_nflt = 1'b0;
    en_drop(lat);
    chk("flt_en_latency", lat, 3);
    wait_done(10, c);
    tick();
    chk("flt_err_code", int'(err_code), 1);
    chk("flt_err", int'(err), 1);
    chk("flt_done_pulses", done_cnt, 1);
    mtr_nflt = 1'b1;
    repeat (4) tick();
    chk("flt_err_held", int'(err_code), 1);
    issue(1'b0, 0);
    chk("flt_err_cleared", int'(err_code), 0);
    wait_done(5, c);
    repeat (2) tick();
    $display("fault: latency=%0d edges=%0d", lat, model_edges);

    // Reset mid-move
    issue(1'b0, 200);
    wait_edges(10, 2000);
    chk("pre_rst_en", int'(mtr_en), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_en", int'(mtr_en), 0);
    chk("mid_rst_div", int'(mtr_div), 8);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    chk("mid_rst_steps", int'(steps_done), 0);
    chk("mid_rst_err_code", int'(err_code), 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_busy", int'(busy), 0);
    $display("reset_mid_move: en=%0d steps_done=%0d", mtr_en, steps_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/film_advance_seq.md
Name: film_advance_seq

Overview:
Motion sequencer directly upstream of the stepper motor_control stage. It accepts move or home-seek commands from the scan controller and drives motor_control's enable and speed divisor. Moves use a trapezoidal (accelerate/cruise/decelerate) divisor profile. The block counts the steps actually issued by watching motor_control's step output, and terminates moves on step count, home sensor, fault, or timeout.

Parameters:
DIV_START, 8'd40, divisor used at standstill/start of ramp (slowest speed)
DIV_RUN, 8'd4, cruise divisor (fastest speed); must be <= DIV_START
RAMP_STEPS, 16, counted steps per 1-unit divisor change during ramps
HOME_MAX, 24'd200000, step limit for home seek before timeout error
SYNC_STAGES, 2, flip-flop stages on async inputs mtr_nhome, mtr_nflt

Ports:
clk_100MHz  in  1  system clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_home  in  1  1 = home seek, 0 = counted move
cmd_steps  in  24  step count for counted move (ignored for home)
mtr_en  out  1  to motor_control en
mtr_div  out  8  to motor_control div
mtr_step_fb  in  1  motor_control step output (synchronous to clk_100MHz)
mtr_nhome  in  1  home sensor, active low, asynchronous
mtr_nflt  in  1  driver fault, active low, asynchronous
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on command completion (success or error)
err  out  1  high while err_code != 0
err_code  out  2  0 none, 1 driver fault, 2 home timeout; held until next accepted command
steps_done  out  24  rising edges counted for current/last command; held after completion

Behaviour:
- Reset: state IDLE; mtr_en=0, mtr_div=DIV_START, cmd_ready=1, busy=0, done=0, err=0, err_code=0, steps_done=0, sync chains to 1, step edge register to 0. Reset mid-move takes effect on that edge; mtr_en drops immediately (registered).
- Step counting: step = rising edge of mtr_step_fb (registered prev value); counted only when mtr_en=1. Counter saturates at 24'hFFFFFF.
- All outputs registered.
- States: IDLE, ACCEL, CRUISE, DECEL, HOME, FINISH.
- IDLE: on accept, latch cmd_home and cmd_steps; clear steps_done and err_code; mtr_div=DIV_START.
  - cmd_home=0, cmd_steps=0 -> FINISH; mtr_en is never asserted.
  - cmd_home=0, otherwise -> ACCEL with mtr_en=1.
  - cmd_home=1 -> HOME.
- ACCEL: every RAMP_STEPS counted steps, mtr_div decrements by 1; when mtr_div reaches DIV_RUN -> CRUISE. accel_steps records the steps taken in ACCEL.
- Decel trigger (ACCEL or CRUISE): when (target - steps_done) <= accel_steps, go to DECEL. Checked after each counted step. For short moves this occurs before DIV_RUN is reached, giving a triangular profile.
- DECEL: every RAMP_STEPS counted steps, mtr_div increments by 1, clamped at DIV_START.
- Move termination: the cycle after steps_done reaches target in any move state, mtr_en=0 and the state goes to FINISH. Exactly target edges are issued.
- HOME: mtr_en=1, mtr_div=DIV_START constant.
  - Synced mtr_nhome==0 -> mtr_en=0, FINISH, err_code=0. If home is already asserted on entry, no steps are issued.
  - steps_done == HOME_MAX -> mtr_en=0, err_code=2, FINISH.
- Fault: synced mtr_nflt==0 in any non-IDLE state has priority over all other transitions. It forces mtr_en=0 next cycle, sets err_code=1, and goes to FINISH. A fault while IDLE is ignored until a command is accepted.
- FINISH: one cycle; done=1; mtr_div=DIV_START; next state IDLE. cmd_ready stays low during FINISH.
- Sensor latency: pin change to mtr_en=0 is SYNC_STAGES+1 cycles.

Test Plan:
1. Assert rst for 2 cycles mid-move (mtr_en=1) -> next cycle mtr_en=0, mtr_div=DIV_START, cmd_ready=1, steps_done=0, err_code=0.
2. DIV_START=8, DIV_RUN=4, RAMP_STEPS=2, bench models motor_control, move 40 steps:
   - mtr_div goes 8,7,6,5,4, with 4 reached after 8 steps.
   - Cruise lasts until 8 steps remain, then div ramps 4->8.
   - Exactly 40 rising edges, steps_done=40, single done pulse, err=0.
3. Same parameters, move 6 steps -> mtr_div never reaches 4 and returns toward 8; exactly 6 edges; done pulse.
4. cmd_steps=0 -> accepted; mtr_en stays 0; done pulses 2 cycles after accept; steps_done=0.
5. Home seek:
   - mtr_nhome driven low after 50 edges -> mtr_en=0 within 3 cycles, done, err_code=0.
   - Repeat with HOME_MAX=100 and mtr_nhome held high -> stops at steps_done=100, err_code=2.
6. mtr_nflt pulled low at step 20 of a 200-step move -> mtr_en=0 within 3 cycles, err_code=1, done pulse. The next accepted command clears err_code.
